// File: rtl/dram_rqst_arbiter.sv
// rtl/dram_rqst_arbiter.sv - round-robin DRAM request arbiter with lock and one-entry output register
module dram_rqst_arbiter #(
  parameter int NUM_REQ                   = 4,
  parameter int DRAM_RQST_FIFO_DATA_WIDTH = 45
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic [NUM_REQ*DRAM_RQST_FIFO_DATA_WIDTH-1:0] i_rqst_data,
  input  logic [NUM_REQ-1:0]                           i_rqst_valid,
  input  logic [NUM_REQ-1:0]                           i_rqst_lock,
  output logic [NUM_REQ-1:0]                           o_rqst_ready,
  output logic [DRAM_RQST_FIFO_DATA_WIDTH-1:0]         o_dram_rqst_fifo_data,
  output logic                                         o_dram_rqst_fifo_we,
  input  logic                                         i_dram_rqst_fifo_full,
  output logic                                         o_err_zero_len,
  output logic [1:0]                                   o_state,
  output logic [2:0]                                   o_grant_id,
  output logic [15:0]                                  o_issued_count
);

  localparam int W = DRAM_RQST_FIFO_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1
  } state_t;

  state_t         state;
  logic [2:0]     lock_id;
  logic [2:0]     last_grant;
  logic           out_valid;
  logic [W-1:0]   out_data;

  // Requester vectors padded to 8 so a 3-bit id indexes them directly
  logic [7:0]     valid_pad;
  logic [7:0]     lock_pad;
  logic [W-1:0]   req_data [8];

  logic           slot_free;
  logic           win_found;
  logic [2:0]     win_id;
  logic [3:0]     idx;
  logic [W-1:0]   sel_data;
  logic           accept;
  logic           zero_len;

  assign valid_pad = 8'(i_rqst_valid);
  assign lock_pad  = 8'(i_rqst_lock);

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < NUM_REQ) begin : g_real
      assign req_data[k] = i_rqst_data[k*W +: W];
    end else begin : g_zero
      assign req_data[k] = '0;
    end
  end

  assign o_dram_rqst_fifo_we   = out_valid && !i_dram_rqst_fifo_full;
  assign o_dram_rqst_fifo_data = out_data;
  assign o_state               = state;

  // The slot can take a new beat if empty or if it drains this cycle
  assign slot_free = !out_valid || o_dram_rqst_fifo_we;

  // Winner search: locked owner only, else round-robin after last_grant
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 4'd0;
    if (state == ST_LOCKED) begin
      win_found = valid_pad[lock_id];
      win_id    = lock_id;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = {1'b0, last_grant} + 4'(i);
        if (idx >= 4'(NUM_REQ)) begin
          idx = idx - 4'(NUM_REQ);
        end
        if (!win_found && valid_pad[idx[2:0]]) begin
          win_found = 1'b1;
          win_id    = idx[2:0];
        end
      end
    end
  end

  assign sel_data = req_data[win_id];
  assign accept   = i_rst_n && slot_free && win_found;
  assign zero_len = (sel_data[12:1] == 12'd0);

  // One-hot ready for the accepted winner only
  always_comb begin
    o_rqst_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_rqst_ready[k] = accept && (win_id == 3'(k));
    end
  end

  // Arbitration FSM: lock ownership, last grant and reported grant id
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      lock_id    <= 3'd0;
      last_grant <= 3'(NUM_REQ - 1);
      o_grant_id <= 3'd0;
    end else if (accept) begin
      last_grant <= win_id;
      o_grant_id <= win_id;
      case (state)
        ST_IDLE: begin
          if (lock_pad[win_id]) begin
            state   <= ST_LOCKED;
            lock_id <= win_id;
          end
        end
        ST_LOCKED: begin
          if (!lock_pad[win_id]) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register, zero-length drop pulse and write counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      o_err_zero_len <= 1'b0;
      o_issued_count <= 16'd0;
    end else begin
      o_err_zero_len <= accept && zero_len;
      if (o_dram_rqst_fifo_we) begin
        o_issued_count <= o_issued_count + 16'd1;
      end
      if (accept && !zero_len) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
      end else if (o_dram_rqst_fifo_we) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_rqst_arbiter.sv
// tb/tb_dram_rqst_arbiter.sv - scoreboard bench for dram_rqst_arbiter
module tb_dram_rqst_arbiter;

  localparam int N = 4;
  localparam int W = 45;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] rqst_data;
  logic [N-1:0]   rqst_valid;
  logic [N-1:0]   rqst_lock;
  logic [N-1:0]   rqst_ready;
  logic [W-1:0]   fifo_data;
  logic           fifo_we;
  logic           fifo_full;
  logic           err_zero_len;
  logic [1:0]     state;
  logic [2:0]     grant_id;
  logic [15:0]    issued_count;

  logic [W-1:0]   req_d [N];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_last;
  bit          m_locked;
  int          m_lock_id;
  bit          m_held;
  logic [W-1:0] m_out;
  logic [15:0] m_cnt;
  bit          m_err;
  int          m_grant;
  logic [W-1:0] exp_q [$];

  assign rqst_data = {req_d[3], req_d[2], req_d[1], req_d[0]};

  dram_rqst_arbiter #(.NUM_REQ(N), .DRAM_RQST_FIFO_DATA_WIDTH(W)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_rqst_data           (rqst_data),
    .i_rqst_valid          (rqst_valid),
    .i_rqst_lock           (rqst_lock),
    .o_rqst_ready          (rqst_ready),
    .o_dram_rqst_fifo_data (fifo_data),
    .o_dram_rqst_fifo_we   (fifo_we),
    .i_dram_rqst_fifo_full (fifo_full),
    .o_err_zero_len        (err_zero_len),
    .o_state               (state),
    .o_grant_id            (grant_id),
    .o_issued_count        (issued_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [11:0] len, input logic rnw);
    return {a, len, rnw};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last    = N - 1;
    m_locked  = 0;
    m_lock_id = 0;
    m_held    = 0;
    m_out     = '0;
    m_cnt     = 16'd0;
    m_err     = 0;
    m_grant   = 0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] rand_entry();
    logic [11:0] len;
    len = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
    return mk($urandom, len, 1'($urandom));
  endfunction

  // One clock cycle: drive, predict, check at negedge, advance the model
  task automatic do_cycle(input logic [3:0] v, input logic [3:0] lk, input logic full_i, output int winner);
    bit           we_e;
    bit           free;
    int           win;
    logic [3:0]   er;
    logic [W-1:0] d;
    rqst_valid = v;
    rqst_lock  = lk;
    fifo_full  = full_i;
    we_e = m_held && !full_i;
    free = !m_held || we_e;
    win  = -1;
    if (free) begin
      if (m_locked) begin
        if (v[m_lock_id]) win = m_lock_id;
      end else begin
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_last + i) % N;
          if (win < 0 && v[k]) win = k;
        end
      end
    end
    er = (win >= 0) ? 4'(1 << win) : 4'b0;
    @(negedge clk);
    chk("ready", 64'(rqst_ready), 64'(er));
    chk("fifo_we", 64'(fifo_we), 64'(we_e));
    chk("fifo_data", 64'(fifo_data), 64'(m_out));
    chk("state", 64'(state), m_locked ? 64'd1 : 64'd0);
    chk("grant_id", 64'(grant_id), 64'(m_grant));
    chk("issued_count", 64'(issued_count), 64'(m_cnt));
    chk("err_zero_len", 64'(err_zero_len), 64'(m_err));
    m_err = 0;
    if (we_e) begin
      m_cnt  = m_cnt + 16'd1;
      m_held = 0;
    end
    if (win >= 0) begin
      d       = req_d[win];
      m_last  = win;
      m_grant = win;
      if (d[12:1] == 12'd0) begin
        m_err = 1;
      end else begin
        m_held = 1;
        m_out  = d;
        exp_q.push_back(d);
      end
      if (!m_locked && lk[win]) begin
        m_locked  = 1;
        m_lock_id = win;
      end else if (m_locked && !lk[win]) begin
        m_locked = 0;
      end
    end
    @(posedge clk);
    #1;
    winner = win;
  endtask

  task automatic apply_reset();
    rqst_valid = 4'hF;
    rqst_lock  = 4'h0;
    fifo_full  = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_we", 64'(fifo_we), 64'd0);
    chk("rst_ready", 64'(rqst_ready), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_count", 64'(issued_count), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_err", 64'(err_zero_len), 64'd0);
    chk("rst_data", 64'(fifo_data), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready_hold", 64'(rqst_ready), 64'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // FIFO-side monitor: every write must match the oldest accepted entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fifo_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fifo_unexpected_write actual=%0h expected=none", fifo_data);
        end else begin
          chk("fifo_order", 64'(fifo_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int w;
    int beats;
    logic [W-1:0] bp_entry;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) req_d[k] = mk(32'h100 * k, 12'd16, 1'b1);
    model_reset();
    #2;
    apply_reset();

    // Round-robin from reset: 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < N; k++) req_d[k] = mk($urandom, 12'($urandom_range(1, 4095)), 1'b0);
      do_cycle(4'hF, 4'h0, 1'b0, w);
      chk("rr_order", 64'(w), 64'(c % 4));
    end
    do_cycle(4'h0, 4'h0, 1'b0, w);
    chk("rr_count", 64'(issued_count), 64'd8);

    // Lock: requester 2 sends 3 beats while 0 and 1 stay valid
    beats = 0;
    for (int c = 0; c < 30 && beats < 3; c++) begin
      for (int k = 0; k < N; k++) req_d[k] = mk($urandom, 12'd64, 1'b1);
      do_cycle(4'b0111, (beats < 2) ? 4'b0100 : 4'b0000, 1'b0, w);
      if (beats > 0) chk("lock_contig", 64'(w), 64'd2);
      if (w == 2) beats++;
    end
    chk("lock_beats", 64'(beats), 64'd3);
    do_cycle(4'b0111, 4'h0, 1'b0, w);
    chk("after_lock", 64'(w), 64'd0);

    // Backpressure: one held entry, FIFO full for 5 cycles
    do_cycle(4'h0, 4'h0, 1'b0, w);
    bp_entry = mk(32'h1000_0000, 12'hFE0, 1'b1);
    req_d[0] = bp_entry;
    do_cycle(4'b0001, 4'h0, 1'b0, w);
    for (int c = 0; c < 5; c++) begin
      do_cycle(4'hF, 4'h0, 1'b1, w);
      chk("bp_no_grant", 64'(w + 1), 64'd0);
      chk("bp_data", 64'(fifo_data), 64'(bp_entry));
    end
    do_cycle(4'h0, 4'h0, 1'b0, w);

    // Zero-length entry from requester 1
    req_d[1] = mk(32'hDEAD_0000, 12'd0, 1'b0);
    do_cycle(4'b0010, 4'h0, 1'b0, w);
    chk("zl_winner", 64'(w), 64'd1);
    do_cycle(4'h0, 4'h0, 1'b0, w);
    do_cycle(4'h0, 4'h0, 1'b0, w);

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) req_d[k] = rand_entry();
      do_cycle(4'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), w);
    end

    // Reset while locked with an entry held
    req_d[0] = mk(32'hA000_0000, 12'd32, 1'b0);
    do_cycle(4'b0001, 4'b0001, 1'b0, w);
    if (m_locked && m_held) begin
      chk("pre_rst_state", 64'(state), 64'd1);
    end
    apply_reset();
    for (int k = 0; k < N; k++) req_d[k] = mk(32'h2000 + k, 12'd8, 1'b1);
    do_cycle(4'hF, 4'h0, 1'b0, w);
    chk("post_rst_first", 64'(w), 64'd0);

    // Counter wrap
    for (int c = 0; c < 70000 && m_cnt != 16'hFFFF; c++) begin
      do_cycle(4'hF, 4'h0, 1'b0, w);
    end
    do_cycle(4'hF, 4'h0, 1'b0, w);
    chk("wrap", 64'(issued_count), 64'd0);

    do_cycle(4'h0, 4'h0, 1'b0, w);
    do_cycle(4'h0, 4'h0, 1'b0, w);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
